// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master drives the run request and ratio loads; the slave returns status and outputs.
interface clk_div_prog_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] div_val;
    logic             div_load;
    logic             div_busy;
    logic             div_ack;
    logic             div_err;
    logic             clk_out;
    logic             tick;

    modport master (
        output enable, div_val, div_load,
        input  div_busy, div_ack, div_err, clk_out, tick
    );

    modport slave (
        input  enable, div_val, div_load,
        output div_busy, div_ack, div_err, clk_out, tick
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider (N >= 2) with a 50% duty output and a per-period tick.
// Ratio changes and start/stop are applied only at output-period boundaries.
module clk_div_prog #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    clk_div_prog_if.slave      bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             clk_p_q, clk_p_d;
    logic             clk_n_q;

    logic             boundary;
    logic             accept;
    logic             apply;
    logic [WIDTH:0]   n_inc;

    always_comb begin
        boundary = (state_q == RUN) && (cnt_q == n_q - WIDTH'(1));
        accept   = bus.div_load && !busy_q && (bus.div_val >= WIDTH'(2));
        apply    = busy_q && (boundary || (state_q == IDLE));

        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        ack_d   = apply;
        err_d   = bus.div_load && !accept;

        if (apply) begin
            n_d    = pend_q;
            busy_d = 1'b0;
        end
        if (accept) begin
            pend_d = bus.div_val;
            busy_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.enable) state_d = RUN;
            end
            RUN: begin
                cnt_d = boundary ? '0 : cnt_q + WIDTH'(1);
                if (boundary && !bus.enable) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // High phase is ceil(N/2) counts of the ratio in force for the coming period.
        n_inc   = {1'b0, n_d} + {{WIDTH{1'b0}}, 1'b1};
        clk_p_d = (state_d == RUN) && (cnt_d < n_inc[WIDTH:1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= WIDTH'(DEFAULT_DIV);
            pend_q  <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            clk_p_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            clk_p_q <= clk_p_d;
        end
    end

    // Half-cycle delayed copy; ANDed in for odd ratios to trim the high phase by half a source period.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) clk_n_q <= 1'b0;
        else        clk_n_q <= clk_p_q;
    end

    assign bus.div_busy = busy_q;
    assign bus.div_ack  = ack_q;
    assign bus.div_err  = err_q;
    assign bus.tick     = boundary;
    assign bus.clk_out  = n_q[0] ? (clk_p_q & clk_n_q) : clk_p_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized self-checking bench for clk_div_prog against a period-position reference model.
// clk_out is predicted per half source cycle from the ratio and position in the output period.
module tb_clk_div_prog;
    localparam int unsigned WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    clk_div_prog_if #(.WIDTH(WIDTH)) bus ();

    clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: running flag, position within the output period, ratio, pending ratio.
    bit m_run;
    int m_pos;
    int m_n;
    int m_pend;
    bit m_busy;
    bit m_ack;
    bit m_err;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_pos  = 0;
        m_n    = 3;
        m_pend = 0;
        m_busy = 0;
        m_ack  = 0;
        m_err  = 0;
    endtask

    task automatic model_edge(input bit en, input bit ld, input int val);
        bit bnd;
        bit acc;
        bnd   = m_run && (m_pos == m_n - 1);
        acc   = ld && !m_busy && (val >= 2);
        m_err = ld && !acc;
        m_ack = m_busy && (bnd || !m_run);
        if (m_ack) begin
            m_n    = m_pend;
            m_busy = 0;
        end
        if (acc) begin
            m_pend = val;
            m_busy = 1;
        end
        if (!m_run || bnd) begin
            m_run = en;
            m_pos = 0;
        end else begin
            m_pos = m_pos + 1;
        end
    endtask

    // Odd N: output high during half-cycles 1..N; even N: half-cycles 0..N-1.
    function automatic int exp_clk(input int half);
        int h;
        h = 2 * m_pos + half;
        if (!m_run) return 0;
        if (m_n % 2 == 1) return int'(h >= 1 && h <= m_n);
        return int'(h < m_n);
    endfunction

    task automatic cycle(input bit en, input bit ld, input int val);
        bus.enable   = en;
        bus.div_load = ld;
        bus.div_val  = WIDTH'(val);
        @(posedge clk);
        model_edge(en, ld, val);
        #1;
        check("tick",     int'(bus.tick),     int'(m_run && (m_pos == m_n - 1)));
        check("div_busy", int'(bus.div_busy), int'(m_busy));
        check("div_ack",  int'(bus.div_ack),  int'(m_ack));
        check("div_err",  int'(bus.div_err),  int'(m_err));
        check("clk_out_hi_half", int'(bus.clk_out), exp_clk(0));
        @(negedge clk);
        #1;
        check("clk_out_lo_half", int'(bus.clk_out), exp_clk(1));
        bus.div_load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_clk_out",  int'(bus.clk_out),  0);
        check("rst_tick",     int'(bus.tick),     0);
        check("rst_div_busy", int'(bus.div_busy), 0);
        check("rst_div_ack",  int'(bus.div_ack),  0);
        check("rst_div_err",  int'(bus.div_err),  0);
        bus.div_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.div_load = 1'b0;
        bus.div_val  = '0;
        model_reset();
        #3;
        check("init_clk_out",  int'(bus.clk_out),  0);
        check("init_tick",     int'(bus.tick),     0);
        check("init_div_busy", int'(bus.div_busy), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Default ratio 3
        for (int i = 0; i < 9; i++) cycle(1, 0, 0);

        // Switch to 4 while running
        cycle(1, 1, 4);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);

        // Illegal ratios rejected
        cycle(1, 1, 1);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);

        // Load while busy: 7 applied, 5 discarded
        cycle(1, 1, 7);
        cycle(1, 1, 5);
        for (int i = 0; i < 12; i++) cycle(1, 0, 0);

        // Drop enable at position 2 of an N=7 period
        for (int i = 0; i < 20; i++) begin
            if (m_run && m_n == 7 && m_pos == 2) break;
            cycle(1, 0, 0);
        end
        for (int i = 0; i < 12; i++) cycle(0, 0, 0);

        // Load 6 in idle, run, reset during the high phase
        cycle(0, 1, 6);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (m_run && m_pos == 1) break;
            cycle(1, 0, 0);
        end
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit en;
            bit ld;
            int val;
            en  = ($urandom % 8) != 0;
            ld  = ($urandom % 6) == 0;
            val = int'($urandom % 12);
            if ($urandom % 400 == 0) do_reset();
            cycle(en, ld, val);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
